// File: rtl/pipelined_adder.sv
// pipelined_adder
//   WIDTH-bit adder/subtractor whose carry ripples one CW-bit chunk per clock
//   (CW = WIDTH/STAGES), producing the sum plus ARM-style NZCV flags.
//   Every stage register holds together when the output is back-pressured.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset, clears every pipeline register
//   in_valid   operand set present
//   in_ready   block accepts this cycle (combinational, = advance)
//   a, b       operands
//   sub        1: a - b (b inverted, carry-in 1); 0: a + b
//   out_valid  result present
//   out_ready  consumer accepts result
//   sum        result, modulo 2^WIDTH
//   flag_n     sum[WIDTH-1]
//   flag_z     sum == 0
//   flag_c     carry out of bit WIDTH-1 (sub: 1 = no borrow)
//   flag_v     signed overflow
module pipelined_adder #(
    parameter int WIDTH  = 64,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage state: index k is the register written by stage k.
    logic [STAGES-1:0]            vld_d,  vld_q;
    logic [STAGES-1:0]            cry_d,  cry_q;
    logic [STAGES-1:0]            zero_d, zero_q;
    logic [STAGES-1:0][WIDTH-1:0] opa_d,  opa_q;
    logic [STAGES-1:0][WIDTH-1:0] opb_d,  opb_q;
    logic [STAGES-1:0][WIDTH-1:0] acc_d,  acc_q;
    logic                         ovf_d,  ovf_q;

    // Scratch values for the per-stage chunk computation.
    logic [WIDTH-1:0] a_in, b_in, s_in;
    logic             c_in, z_in, v_in;
    logic [CW-1:0]    ca, cb;
    logic [CW:0]      part;
    logic             advance;

    // The whole pipeline moves as one: either every stage shifts or none does.
    assign advance  = !vld_q[LAST] || out_ready;
    assign in_ready = advance;

    always_comb begin
        vld_d  = '0;
        cry_d  = '0;
        zero_d = '0;
        opa_d  = '0;
        opb_d  = '0;
        acc_d  = '0;
        ovf_d  = 1'b0;
        a_in   = '0;
        b_in   = '0;
        s_in   = '0;
        c_in   = 1'b0;
        z_in   = 1'b0;
        v_in   = 1'b0;
        ca     = '0;
        cb     = '0;
        part   = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                // B is inverted up front; carry-in = sub completes two's complement.
                a_in = a;
                b_in = b ^ {WIDTH{sub}};
                s_in = '0;
                c_in = sub;
                z_in = 1'b1;
                v_in = in_valid;
            end else begin
                a_in = opa_q[(k == 0) ? 0 : k - 1];
                b_in = opb_q[(k == 0) ? 0 : k - 1];
                s_in = acc_q[(k == 0) ? 0 : k - 1];
                c_in = cry_q[(k == 0) ? 0 : k - 1];
                z_in = zero_q[(k == 0) ? 0 : k - 1];
                v_in = vld_q[(k == 0) ? 0 : k - 1];
            end
            ca   = a_in[k*CW +: CW];
            cb   = b_in[k*CW +: CW];
            part = {1'b0, ca} + {1'b0, cb} + {{CW{1'b0}}, c_in};
            s_in[k*CW +: CW] = part[CW-1:0];

            acc_d[k]  = s_in;
            cry_d[k]  = part[CW];
            zero_d[k] = z_in & (part[CW-1:0] == '0);
            vld_d[k]  = v_in;
            opa_d[k]  = a_in;
            opb_d[k]  = b_in;
            if (k == LAST) begin
                // Carry into the MSB is recovered from the MSB sum bit and its inputs.
                ovf_d = (part[CW-1] ^ ca[CW-1] ^ cb[CW-1]) ^ part[CW];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_q  <= '0;
            cry_q  <= '0;
            zero_q <= '0;
            opa_q  <= '0;
            opb_q  <= '0;
            acc_q  <= '0;
            ovf_q  <= 1'b0;
        end else if (advance) begin
            vld_q  <= vld_d;
            cry_q  <= cry_d;
            zero_q <= zero_d;
            opa_q  <= opa_d;
            opb_q  <= opb_d;
            acc_q  <= acc_d;
            ovf_q  <= ovf_d;
        end
    end

    assign out_valid = vld_q[LAST];
    assign sum       = acc_q[LAST];
    assign flag_n    = acc_q[LAST][WIDTH-1];
    assign flag_z    = zero_q[LAST];
    assign flag_c    = cry_q[LAST];
    assign flag_v    = ovf_q;

    // Skew registers of the last stage (and used-up chunks) have no reader.
    logic unused_skew;
    assign unused_skew = ^{opa_q, opb_q};

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a, b;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        flag_n, flag_z, flag_c, flag_v;

    int errors = 0;
    int checks = 0;

    pipelined_adder #(.WIDTH(64), .STAGES(4)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, got time %0t want < 200000", $time);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] nzcv();
        return {60'd0, flag_n, flag_z, flag_c, flag_v};
    endfunction

    // One operation through an empty pipeline; latency counted in edges after acceptance.
    task automatic run_op(input string tag, input logic [63:0] av, input logic [63:0] bv,
                          input logic sv, input logic [63:0] exp_sum, input logic [3:0] exp_f);
        int n;
        a = av; b = bv; sub = sv; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'd3);
        check({tag, "_sum"}, sum, exp_sum);
        check({tag, "_nzcv"}, nzcv(), {60'd0, exp_f});
        @(posedge clk); #1;
        check({tag, "_drained"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int idx, got, stall_cnt;
        logic stalling, acc, cons;

        reset_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b0;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            a = {$urandom, $urandom}; b = {$urandom, $urandom};
            sub = 1'($urandom); in_valid = 1'b1; out_ready = 1'($urandom);
            @(posedge clk); #1;
            check("rst_out_valid", {63'd0, out_valid}, 64'd0);
            check("rst_sum", sum, 64'd0);
            check("rst_flags", nzcv(), 64'd0);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        reset_n = 1'b1;
        #1;
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 4'b0110);
        run_op("sub_5_7", 64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 4'b1000);
        run_op("sub_7_5", 64'd7, 64'd5, 1'b1, 64'd2, 4'b0010);
        run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 4'b1001);

        // Stream 6 adds; after the first result is taken, out_ready drops for 3 cycles
        idx = 0; got = 0; stall_cnt = 0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            stalling  = (stall_cnt > 0);
            out_ready = !stalling;
            in_valid  = (idx < 6);
            a   = 64'(idx + 1);
            b   = 64'(10 * (idx + 1));
            sub = 1'b0;
            #1;
            if (stalling) begin
                check("stall_in_ready", {63'd0, in_ready}, 64'd0);
                check("stall_out_valid", {63'd0, out_valid}, 64'd1);
                check("stall_hold", sum, 64'(11 * (got + 1)));
            end
            acc  = in_valid && in_ready;
            cons = out_valid && out_ready;
            if (cons) begin
                check("stream_sum", sum, 64'(11 * (got + 1)));
                got++;
            end
            @(posedge clk); #1;
            if (acc) idx++;
            if (stalling) stall_cnt--;
            else if (cons && got == 1) stall_cnt = 3;
        end
        in_valid = 1'b0;
        check("stream_count", 64'(got), 64'd6);
        check("stream_sent", 64'(idx), 64'd6);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("stream_no_dup", {63'd0, out_valid}, 64'd0);
        end

        // Reset while three operations are in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 64'(100 + i); b = 64'd1; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("mid_valid_before", {63'd0, out_valid}, 64'd1);
        check("mid_sum_before", sum, 64'd101);
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_sum", sum, 64'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("post_rst_no_stale", {63'd0, out_valid}, 64'd0);
        end
        run_op("post_rst_3_4", 64'd3, 64'd4, 1'b0, 64'd7, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
